// File: rtl/addsub_pkg.sv
// Shared encodings for the digit-serial adder/subtractor:
// FSM state constants and operation select values.
package addsub_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/addsub_digit.sv
// Combinational DIGIT-bit ripple adder built from full-adder cells; also exposes
// the carry into its top bit so the caller can derive signed overflow.
module addsub_digit #(
   parameter int DIGIT = 4
) (
   input  logic [DIGIT-1:0] i_a,
   input  logic [DIGIT-1:0] i_b,
   input  logic             i_cin,
   output logic [DIGIT-1:0] o_sum,
   output logic             o_cout,
   output logic             o_c_top
);

   logic [DIGIT:0] w_c;

   assign w_c[0] = i_cin;

   genvar gi;
   generate
      for (gi = 0; gi < DIGIT; gi++) begin : g_fa
         full_adder u_fa (
            .i_a (i_a[gi]),
            .i_b (i_b[gi]),
            .i_c (w_c[gi]),
            .o_s (o_sum[gi]),
            .o_c (w_c[gi+1])
         );
      end
   endgenerate

   assign o_cout  = w_c[DIGIT];
   assign o_c_top = w_c[DIGIT-1];

endmodule

// File: rtl/full_adder.sv
// Single-bit full-adder cell used as the building block of the digit ripple chain.
module full_adder (
   input  logic i_a,
   input  logic i_b,
   input  logic i_c,
   output logic o_s,
   output logic o_c
);

   assign o_s = i_a ^ i_b ^ i_c;
   assign o_c = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);

endmodule

// File: rtl/digit_serial_addsub.sv
// Multi-cycle WIDTH-bit adder/subtractor: one DIGIT-bit slice per clock, carry
// registered between slices, start/busy/done handshake with carry/overflow/zero flags.
module digit_serial_addsub
   import addsub_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             op,
   input  logic             carry_in,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             overflow,
   output logic             zero,
   output logic             busy,
   output logic             done
);

   localparam int N     = WIDTH / DIGIT;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

   logic [1:0]       r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_carry;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_result;
   logic             r_carry_out;
   logic             r_overflow;
   logic             r_zero;

   logic [DIGIT-1:0] w_sum;
   logic             w_cout;
   logic             w_c_top;
   logic [WIDTH-1:0] w_result_next;
   logic             w_accept;

   // Operands are shifted right each cycle so the active digit is always the low slice.
   addsub_digit #(
      .DIGIT (DIGIT)
   ) u_digit (
      .i_a     (r_a[DIGIT-1:0]),
      .i_b     (r_b[DIGIT-1:0]),
      .i_cin   (r_carry),
      .o_sum   (w_sum),
      .o_cout  (w_cout),
      .o_c_top (w_c_top)
   );

   always_comb begin
      w_result_next = r_result;
      w_result_next[int'(r_cnt) * DIGIT +: DIGIT] = w_sum;
   end

   assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_a         <= '0;
         r_b         <= '0;
         r_carry     <= 1'b0;
         r_cnt       <= '0;
         r_result    <= '0;
         r_carry_out <= 1'b0;
         r_overflow  <= 1'b0;
         r_zero      <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (w_accept) begin
                  r_a         <= A;
                  r_b         <= (op == OP_SUB) ? ~B : B;
                  r_carry     <= (op == OP_SUB) ? 1'b1 : carry_in;
                  r_cnt       <= '0;
                  r_carry_out <= 1'b0;
                  r_overflow  <= 1'b0;
                  r_zero      <= 1'b0;
                  r_state     <= ST_RUN;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_RUN: begin
               r_a      <= r_a >> DIGIT;
               r_b      <= r_b >> DIGIT;
               r_result <= w_result_next;
               r_carry  <= w_cout;
               r_cnt    <= r_cnt + 1'b1;
               if (r_cnt == CNT_LAST) begin
                  r_carry_out <= w_cout;
                  r_overflow  <= w_cout ^ w_c_top;
                  r_zero      <= (w_result_next == '0);
                  r_state     <= ST_DONE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign result    = r_result;
   assign carry_out = r_carry_out;
   assign overflow  = r_overflow;
   assign zero      = r_zero;
   assign busy      = (r_state == ST_RUN);
   assign done      = (r_state == ST_DONE);

endmodule

// File: tb/tb_digit_serial_addsub.sv
// Directed self-checking bench for digit_serial_addsub at WIDTH=16, DIGIT=4.
module tb_digit_serial_addsub;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        op = 1'b0;
   logic        carry_in = 1'b0;
   logic [15:0] A = '0;
   logic [15:0] B = '0;
   logic [15:0] result;
   logic        carry_out;
   logic        overflow;
   logic        zero;
   logic        busy;
   logic        done;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   digit_serial_addsub #(
      .WIDTH (16),
      .DIGIT (4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .op        (op),
      .carry_in  (carry_in),
      .A         (A),
      .B         (B),
      .result    (result),
      .carry_out (carry_out),
      .overflow  (overflow),
      .zero      (zero),
      .busy      (busy),
      .done      (done)
   );

   // Issue one start; returns the number of negedges (after the start edge) until done, or -1.
   task automatic do_op(input logic o, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, output int lat);
      @(negedge clk);
      op = o; A = a; B = b; carry_in = cin; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      A = 16'hDEAD; B = 16'hBEEF; op = ~o; carry_in = ~cin;
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (done) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      int seen_done;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      seen_done = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (done) seen_done++;
      end
      checks++;
      if ({result, carry_out, overflow, zero, busy, done} !== 21'd0) begin
         errors++;
         $display("FAIL reset_outputs: got res=%h co=%b ov=%b z=%b busy=%b done=%b, expected all 0",
                  result, carry_out, overflow, zero, busy, done);
      end
      checks++;
      if (seen_done !== 0) begin
         errors++;
         $display("FAIL reset_no_done: got %0d done pulses, expected 0", seen_done);
      end
      $display("reset: res=%h busy=%b done=%b", result, busy, done);
   endtask

   task automatic test_add();
      int busy_bad;
      @(negedge clk);
      op = 1'b0; A = 16'h00FF; B = 16'h0001; carry_in = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      busy_bad = 0;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         if (busy !== 1'b1 || done !== 1'b0) busy_bad++;
      end
      checks++;
      if (busy_bad !== 0) begin
         errors++;
         $display("FAIL add_busy_window: got %0d bad cycles, expected 0", busy_bad);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL add_done_timing: got done=%b busy=%b, expected done=1 busy=0", done, busy);
      end
      checks++;
      if ({result, carry_out, overflow, zero} !== {16'h0100, 3'b000}) begin
         errors++;
         $display("FAIL add_result: got res=%h co=%b ov=%b z=%b, expected res=0100 co=0 ov=0 z=0",
                  result, carry_out, overflow, zero);
      end
      $display("add 00FF+0001: res=%h co=%b ov=%b z=%b", result, carry_out, overflow, zero);
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || result !== 16'h0100) begin
         errors++;
         $display("FAIL add_done_pulse: got done=%b res=%h, expected done=0 res=0100", done, result);
      end
   endtask

   task automatic test_overflow();
      int lat;
      do_op(1'b0, 16'h7FFF, 16'h0001, 1'b0, lat);
      checks++;
      if (lat !== 5 || {result, carry_out, overflow, zero} !== {16'h8000, 3'b010}) begin
         errors++;
         $display("FAIL ovf_7fff_plus_1: got lat=%0d res=%h co=%b ov=%b z=%b, expected lat=5 res=8000 co=0 ov=1 z=0",
                  lat, result, carry_out, overflow, zero);
      end
      $display("add 7FFF+0001: res=%h co=%b ov=%b z=%b", result, carry_out, overflow, zero);
      do_op(1'b0, 16'hFFFF, 16'h0000, 1'b1, lat);
      checks++;
      if (lat !== 5 || {result, carry_out, overflow, zero} !== {16'h0000, 3'b101}) begin
         errors++;
         $display("FAIL add_ffff_cin: got lat=%0d res=%h co=%b ov=%b z=%b, expected lat=5 res=0000 co=1 ov=0 z=1",
                  lat, result, carry_out, overflow, zero);
      end
      $display("add FFFF+0000+1: res=%h co=%b ov=%b z=%b", result, carry_out, overflow, zero);
   endtask

   task automatic test_subtract();
      int lat;
      do_op(1'b1, 16'h0000, 16'h0001, 1'b0, lat);
      checks++;
      if (lat !== 5 || {result, carry_out, overflow, zero} !== {16'hFFFF, 3'b000}) begin
         errors++;
         $display("FAIL sub_0_minus_1: got lat=%0d res=%h co=%b ov=%b z=%b, expected lat=5 res=FFFF co=0 ov=0 z=0",
                  lat, result, carry_out, overflow, zero);
      end
      $display("sub 0000-0001: res=%h co=%b ov=%b z=%b", result, carry_out, overflow, zero);
      do_op(1'b1, 16'h1234, 16'h1234, 1'b0, lat);
      checks++;
      if (lat !== 5 || {result, carry_out, overflow, zero} !== {16'h0000, 3'b101}) begin
         errors++;
         $display("FAIL sub_equal: got lat=%0d res=%h co=%b ov=%b z=%b, expected lat=5 res=0000 co=1 ov=0 z=1",
                  lat, result, carry_out, overflow, zero);
      end
      $display("sub 1234-1234: res=%h co=%b ov=%b z=%b", result, carry_out, overflow, zero);
      do_op(1'b1, 16'h8000, 16'h0001, 1'b0, lat);
      checks++;
      if (lat !== 5 || {result, carry_out, overflow, zero} !== {16'h7FFF, 3'b110}) begin
         errors++;
         $display("FAIL sub_8000_minus_1: got lat=%0d res=%h co=%b ov=%b z=%b, expected lat=5 res=7FFF co=1 ov=1 z=0",
                  lat, result, carry_out, overflow, zero);
      end
      $display("sub 8000-0001: res=%h co=%b ov=%b z=%b", result, carry_out, overflow, zero);
   endtask

   task automatic test_back_to_back();
      int lat;
      @(negedge clk);
      op = 1'b0; A = 16'h0001; B = 16'h0002; carry_in = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      // Re-pulse start with different operands across edge t+2 while busy.
      op = 1'b1; A = 16'hAAAA; B = 16'h5555; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      lat = -1;
      for (int i = 3; i <= 20; i++) begin
         @(negedge clk);
         if (done) begin
            lat = i;
            break;
         end
      end
      checks++;
      if (lat !== 5 || result !== 16'h0003 || carry_out !== 1'b0) begin
         errors++;
         $display("FAIL busy_start_ignored: got lat=%0d res=%h co=%b, expected lat=5 res=0003 co=0",
                  lat, result, carry_out);
      end
      $display("add 0001+0002 with ignored restart: res=%h", result);
      // Start in the DONE cycle.
      op = 1'b0; A = 16'h1111; B = 16'h2222; carry_in = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (done) begin
            lat = i;
            break;
         end
      end
      checks++;
      if (lat !== 5 || {result, carry_out, overflow, zero} !== {16'h3333, 3'b000}) begin
         errors++;
         $display("FAIL back_to_back: got lat=%0d res=%h co=%b ov=%b z=%b, expected lat=5 res=3333 flags 000",
                  lat, result, carry_out, overflow, zero);
      end
      $display("back-to-back 1111+2222: lat=%0d res=%h", lat, result);
      repeat (3) @(negedge clk);
      checks++;
      if (result !== 16'h3333 || done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL result_hold: got res=%h done=%b busy=%b, expected res=3333 done=0 busy=0",
                  result, done, busy);
      end
   endtask

   task automatic test_reset_mid_op();
      int seen_done;
      int lat;
      // Leave nonzero flags behind first so the reset clearing them is observable.
      do_op(1'b1, 16'h8000, 16'h0001, 1'b0, lat);
      @(negedge clk);
      op = 1'b0; A = 16'h1234; B = 16'h1111; carry_in = 1'b1; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      checks++;
      if ({result, carry_out, overflow, zero, busy, done} !== 21'd0) begin
         errors++;
         $display("FAIL reset_mid_op: got res=%h co=%b ov=%b z=%b busy=%b done=%b, expected all 0",
                  result, carry_out, overflow, zero, busy, done);
      end
      seen_done = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (done || busy) seen_done++;
      end
      checks++;
      if (seen_done !== 0) begin
         errors++;
         $display("FAIL reset_mid_op_no_done: got %0d done/busy cycles, expected 0", seen_done);
      end
      $display("reset mid-op: res=%h busy=%b done=%b", result, busy, done);
   endtask

   initial begin
      test_reset();
      test_add();
      test_overflow();
      test_subtract();
      test_back_to_back();
      test_reset_mid_op();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
